// File: rtl/menu_display.sv
// Vertically stacked N_BUTTONS menu: up/down selection, blink-confirm on select, then valid/ack choice handoff.
// Build macro MENU_WRAP_NAV_EN makes up/down navigation wrap around instead of saturating at the ends.
module menu_display #(
    parameter int          N_BUTTONS    = 3,
    parameter int          X0           = 380,
    parameter int          Y0           = 200,
    parameter int          BTN_W        = 200,
    parameter int          BTN_H        = 100,
    parameter int          GAP          = 50,
    parameter logic [23:0] BTN_COLOR    = 24'hF4_63_05,
    parameter logic [23:0] HL_COLOR     = 24'hFF_FF_FF,
    parameter int          BLINK_FRAMES = 8,
    parameter int          FLASH_FRAMES = 32,
    localparam int         IW           = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [10:0]   hcount_in,
    input  logic [9:0]    vcount_in,
    input  logic          new_frame_in,
    input  logic          nav_up_in,
    input  logic          nav_down_in,
    input  logic          select_in,
    input  logic          ack_in,
    output logic [23:0]   display_out,
    output logic [IW-1:0] sel_idx_out,
    output logic          choice_valid_out,
    output logic [IW-1:0] choice_idx_out
);
    localparam int              FW         = $clog2(FLASH_FRAMES + 1);
    localparam int              BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int              PITCH      = BTN_H + GAP;
    localparam logic [IW-1:0]   MAX_IDX    = IW'(N_BUTTONS - 1);
    localparam logic [FW-1:0]   FLASH_LAST = FW'(FLASH_FRAMES);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [31:0]     X_LO       = 32'(X0);
    localparam logic [31:0]     X_HI       = 32'(X0 + BTN_W);

    typedef enum logic [1:0] {
        ST_BROWSE  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] choice_q, choice_d;
    logic          valid_q, valid_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          blink_off_q, blink_off_d;
    logic [23:0]   display_q, display_d;

    logic [IW-1:0] sel_up, sel_down;
    logic [31:0]   hx, vy;
    logic          in_x, hit_any, hit_sel;

    always_comb begin
`ifdef MENU_WRAP_NAV_EN
        sel_down = (sel_q == MAX_IDX) ? '0 : sel_q + 1'b1;
        sel_up   = (sel_q == '0) ? MAX_IDX : sel_q - 1'b1;
`else
        sel_down = (sel_q == MAX_IDX) ? MAX_IDX : sel_q + 1'b1;
        sel_up   = (sel_q == '0) ? '0 : sel_q - 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        choice_d    = choice_q;
        valid_d     = valid_q;
        frame_d     = frame_q;
        blink_d     = blink_q;
        blink_off_d = blink_off_q;
        case (state_q)
            ST_BROWSE: begin
                // select latches the pre-navigation index even if a nav pulse coincides
                if (select_in) begin
                    choice_d    = sel_q;
                    frame_d     = '0;
                    blink_d     = '0;
                    blink_off_d = 1'b0;
                    state_d     = ST_CONFIRM;
                end else if (nav_down_in && !nav_up_in) begin
                    sel_d = sel_down;
                end else if (nav_up_in && !nav_down_in) begin
                    sel_d = sel_up;
                end
            end
            ST_CONFIRM: begin
                if (new_frame_in) begin
                    frame_d = frame_q + 1'b1;
                    if (blink_q == BLINK_LAST) begin
                        blink_d     = '0;
                        blink_off_d = ~blink_off_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                    if (frame_d == FLASH_LAST) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (ack_in) begin
                    valid_d = 1'b0;
                    state_d = ST_BROWSE;
                end
            end
            default: state_d = ST_BROWSE;
        endcase
    end

    // 32-bit compares so X0+BTN_W and the lowest button bottom can never wrap
    always_comb begin
        hx      = {21'd0, hcount_in};
        vy      = {22'd0, vcount_in};
        in_x    = (hx >= X_LO) && (hx < X_HI);
        hit_any = 1'b0;
        hit_sel = 1'b0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (in_x && (vy >= 32'(Y0 + i * PITCH)) && (vy < 32'(Y0 + i * PITCH + BTN_H))) begin
                hit_any = 1'b1;
                if (sel_q == IW'(i)) hit_sel = 1'b1;
            end
        end
        if (hit_sel)
            display_d = (state_q == ST_CONFIRM && blink_off_q) ? BTN_COLOR : HL_COLOR;
        else if (hit_any)
            display_d = BTN_COLOR;
        else
            display_d = '0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_BROWSE;
            sel_q       <= '0;
            choice_q    <= '0;
            valid_q     <= 1'b0;
            frame_q     <= '0;
            blink_q     <= '0;
            blink_off_q <= 1'b0;
            display_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            choice_q    <= choice_d;
            valid_q     <= valid_d;
            frame_q     <= frame_d;
            blink_q     <= blink_d;
            blink_off_q <= blink_off_d;
            display_q   <= display_d;
        end
    end

    assign display_out      = display_q;
    assign sel_idx_out      = sel_q;
    assign choice_valid_out = valid_q;
    assign choice_idx_out   = choice_q;

endmodule

// File: tb/tb_menu_display.sv
// Self-checking bench for menu_display: directed scenarios plus randomized traffic against a behavioural menu model.
`timescale 1ns/1ps
module tb_menu_display;
    localparam int          N_BUTTONS    = 3;
    localparam int          X0           = 380;
    localparam int          Y0           = 200;
    localparam int          BTN_W        = 200;
    localparam int          BTN_H        = 100;
    localparam int          GAP          = 50;
    localparam logic [23:0] BTN_COLOR    = 24'hF46305;
    localparam logic [23:0] HL_COLOR     = 24'hFFFFFF;
    localparam int          BLINK_FRAMES = 8;
    localparam int          FLASH_FRAMES = 32;
`ifdef MENU_WRAP_NAV_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int M_BROWSE = 0, M_CONFIRM = 1, M_DONE = 2;

    logic        clk_in;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        new_frame_in, nav_up_in, nav_down_in, select_in, ack_in;
    logic [23:0] display_out;
    logic [1:0]  sel_idx_out;
    logic        choice_valid_out;
    logic [1:0]  choice_idx_out;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model of the menu
    int          m_mode, m_sel, m_choice, m_frames;
    bit          m_valid;
    logic [23:0] exp_disp;

    menu_display dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .new_frame_in     (new_frame_in),
        .nav_up_in        (nav_up_in),
        .nav_down_in      (nav_down_in),
        .select_in        (select_in),
        .ack_in           (ack_in),
        .display_out      (display_out),
        .sel_idx_out      (sel_idx_out),
        .choice_valid_out (choice_valid_out),
        .choice_idx_out   (choice_idx_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode   = M_BROWSE;
        m_sel    = 0;
        m_choice = 0;
        m_frames = 0;
        m_valid  = 1'b0;
    endtask

    function automatic logic [23:0] model_pixel(input int h, input int v);
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (h >= X0 && h < X0 + BTN_W && v >= Y0 + i * (BTN_H + GAP) && v < Y0 + i * (BTN_H + GAP) + BTN_H) begin
                if (i != m_sel) return BTN_COLOR;
                if (m_mode == M_CONFIRM && ((m_frames / BLINK_FRAMES) % 2) == 1) return BTN_COLOR;
                return HL_COLOR;
            end
        end
        return 24'h0;
    endfunction

    task automatic model_edge(input bit up, input bit down, input bit sel, input bit nf, input bit ack);
        case (m_mode)
            M_BROWSE: begin
                if (sel) begin
                    m_choice = m_sel;
                    m_frames = 0;
                    m_mode   = M_CONFIRM;
                end else if (down && !up) begin
                    if (m_sel == N_BUTTONS - 1) m_sel = WRAP ? 0 : N_BUTTONS - 1;
                    else m_sel = m_sel + 1;
                end else if (up && !down) begin
                    if (m_sel == 0) m_sel = WRAP ? N_BUTTONS - 1 : 0;
                    else m_sel = m_sel - 1;
                end
            end
            M_CONFIRM: begin
                if (nf) begin
                    m_frames++;
                    if (m_frames == FLASH_FRAMES) begin
                        m_mode  = M_DONE;
                        m_valid = 1'b1;
                    end
                end
            end
            default: begin
                if (ack) begin
                    m_valid = 1'b0;
                    m_mode  = M_BROWSE;
                end
            end
        endcase
    endtask

    // Drive one clock of inputs from a falling edge and return at the next falling edge.
    task automatic drive_cycle(input int h, input int v, input bit up, input bit down,
                               input bit sel, input bit nf, input bit ack);
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        nav_up_in    = up;
        nav_down_in  = down;
        select_in    = sel;
        new_frame_in = nf;
        ack_in       = ack;
        exp_disp     = model_pixel(h, v);
        model_edge(up, down, sel, nf, ack);
        @(negedge clk_in);
        nav_up_in    = 1'b0;
        nav_down_in  = 1'b0;
        select_in    = 1'b0;
        new_frame_in = 1'b0;
        ack_in       = 1'b0;
    endtask

    task automatic test_reset();
        int          ph[6];
        int          pv[6];
        logic [23:0] pe[6];
        ph = '{400, 400, 579, 580, 400, 100};
        pv = '{210, 360, 299, 299, 300, 100};
        pe = '{24'hFFFFFF, 24'hF46305, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000};
        rst_in = 1'b0;
        hcount_in = 11'd400;
        vcount_in = 10'd210;
        model_reset();
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (display_out !== 24'h0) begin n_fail++; $display("FAIL reset_display: got %h want 000000", display_out); end
        n_checks++;
        if (sel_idx_out !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel_idx_out); end
        n_checks++;
        if (choice_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", choice_valid_out); end
        n_checks++;
        if (choice_idx_out !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", choice_idx_out); end
        rst_in = 1'b1;
        @(negedge clk_in);
        for (int k = 0; k < 6; k++) begin
            drive_cycle(ph[k], pv[k], 0, 0, 0, 0, 0);
            n_checks++;
            if (display_out !== pe[k]) begin
                n_fail++;
                $display("FAIL pixel_sweep (%0d,%0d): got %h want %h", ph[k], pv[k], display_out, pe[k]);
            end
        end
    endtask

    task automatic test_nav();
        int seq[3];
        if (WRAP) seq = '{1, 2, 0};
        else      seq = '{1, 2, 2};
        for (int k = 0; k < 3; k++) begin
            drive_cycle(400, 210, 0, 1, 0, 0, 0);
            n_checks++;
            if (sel_idx_out !== 2'(seq[k])) begin
                n_fail++;
                $display("FAIL nav_down_%0d: got %0d want %0d", k, sel_idx_out, seq[k]);
            end
        end
        for (int k = 0; k < 8 && m_sel != 0; k++) drive_cycle(400, 210, 1, 0, 0, 0, 0);
        n_checks++;
        if (sel_idx_out !== 2'd0) begin n_fail++; $display("FAIL nav_to_zero: got %0d want 0", sel_idx_out); end
        drive_cycle(400, 210, 1, 0, 0, 0, 0);
        n_checks++;
        if (sel_idx_out !== (WRAP ? 2'd2 : 2'd0)) begin
            n_fail++;
            $display("FAIL nav_up_at_zero: got %0d want %0d", sel_idx_out, WRAP ? 2 : 0);
        end
        for (int k = 0; k < 8 && m_sel != 1; k++) begin
            if (m_sel > 1) drive_cycle(400, 210, 1, 0, 0, 0, 0);
            else           drive_cycle(400, 210, 0, 1, 0, 0, 0);
        end
        n_checks++;
        if (sel_idx_out !== 2'd1) begin n_fail++; $display("FAIL nav_to_one: got %0d want 1", sel_idx_out); end
    endtask

    task automatic test_edge_events();
        drive_cycle(400, 360, 1, 1, 0, 0, 0);
        n_checks++;
        if (sel_idx_out !== 2'd1) begin n_fail++; $display("FAIL up_down_same_cycle: got %0d want 1", sel_idx_out); end
        drive_cycle(400, 360, 0, 0, 0, 0, 1);
        n_checks++;
        if (display_out !== HL_COLOR) begin n_fail++; $display("FAIL hl_sel1: got %h want %h", display_out, HL_COLOR); end
        n_checks++;
        if (choice_valid_out !== 1'b0) begin n_fail++; $display("FAIL ack_in_browse: got %b want 0", choice_valid_out); end
    endtask

    task automatic test_confirm();
        logic [23:0] want;
        drive_cycle(400, 360, 0, 1, 1, 0, 0);
        n_checks++;
        if (sel_idx_out !== 2'd1) begin n_fail++; $display("FAIL select_with_nav_sel: got %0d want 1", sel_idx_out); end
        for (int f = 0; f < FLASH_FRAMES; f++) begin
            want = (((f / 8) % 2) == 1) ? 24'hF46305 : 24'hFFFFFF;
            drive_cycle(400, 360, f[0], !f[0], (f == 5), 0, 0);
            drive_cycle(400, 360, 0, 0, 0, 0, 1);
            n_checks++;
            if (display_out !== want) begin
                n_fail++;
                $display("FAIL blink_frame_%0d: got %h want %h", f, display_out, want);
            end
            n_checks++;
            if (sel_idx_out !== 2'd1) begin n_fail++; $display("FAIL confirm_sel_frame_%0d: got %0d want 1", f, sel_idx_out); end
            drive_cycle(400, 360, 0, 0, 0, 1, 0);
            n_checks++;
            if (choice_valid_out !== (f == FLASH_FRAMES - 1)) begin
                n_fail++;
                $display("FAIL valid_after_frame_%0d: got %b want %b", f, choice_valid_out, (f == FLASH_FRAMES - 1));
            end
        end
        n_checks++;
        if (choice_idx_out !== 2'd1) begin n_fail++; $display("FAIL choice_idx: got %0d want 1", choice_idx_out); end
    endtask

    task automatic test_done_hold();
        for (int k = 0; k < 100; k++) begin
            drive_cycle(400, 360, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 3) == 0), $urandom_range(0, 1), 0);
            n_checks++;
            if (choice_valid_out !== 1'b1 || choice_idx_out !== 2'd1 || display_out !== HL_COLOR) begin
                n_fail++;
                $display("FAIL done_hold_%0d: got valid=%b idx=%0d pix=%h want valid=1 idx=1 pix=%h",
                         k, choice_valid_out, choice_idx_out, display_out, HL_COLOR);
            end
        end
        drive_cycle(400, 360, 0, 0, 0, 0, 1);
        n_checks++;
        if (choice_valid_out !== 1'b0 || sel_idx_out !== 2'd1) begin
            n_fail++;
            $display("FAIL ack_release: got valid=%b sel=%0d want valid=0 sel=1", choice_valid_out, sel_idx_out);
        end
        drive_cycle(400, 360, 0, 1, 0, 0, 0);
        n_checks++;
        if (sel_idx_out !== 2'd2) begin n_fail++; $display("FAIL browse_after_ack: got %0d want 2", sel_idx_out); end
        drive_cycle(400, 360, 1, 0, 0, 0, 0);
        n_checks++;
        if (sel_idx_out !== 2'd1) begin n_fail++; $display("FAIL browse_back_up: got %0d want 1", sel_idx_out); end
    endtask

    task automatic test_async_reset();
        drive_cycle(400, 360, 0, 0, 1, 0, 0);
        for (int f = 0; f < 10; f++) drive_cycle(400, 360, 0, 0, 0, 1, 0);
        drive_cycle(400, 360, 0, 0, 0, 0, 0);
        n_checks++;
        if (display_out !== BTN_COLOR) begin n_fail++; $display("FAIL pre_reset_pix: got %h want %h", display_out, BTN_COLOR); end
        #2;
        rst_in = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (sel_idx_out !== 2'd0 || choice_valid_out !== 1'b0 || display_out !== 24'h0) begin
            n_fail++;
            $display("FAIL async_reset: got sel=%0d valid=%b pix=%h want 0 0 000000",
                     sel_idx_out, choice_valid_out, display_out);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int k = 0; k < 60; k++) begin
            drive_cycle(400, 360, 0, 0, 0, k[0], 0);
            n_checks++;
            if (choice_valid_out !== 1'b0 || sel_idx_out !== 2'd0) begin
                n_fail++;
                $display("FAIL post_reset_%0d: got valid=%b sel=%0d want 0 0", k, choice_valid_out, sel_idx_out);
            end
        end
    endtask

    task automatic test_random();
        int h, v;
        for (int k = 0; k < 1500; k++) begin
            h = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(360, 600);
            v = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(180, 720);
            drive_cycle(h, v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 15) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
            n_checks++;
            if (display_out !== exp_disp) begin
                n_fail++;
                $display("FAIL rand_pix_%0d (%0d,%0d): got %h want %h", k, h, v, display_out, exp_disp);
            end
            n_checks++;
            if (sel_idx_out !== 2'(m_sel) || choice_valid_out !== m_valid) begin
                n_fail++;
                $display("FAIL rand_state_%0d: got sel=%0d valid=%b want sel=%0d valid=%b",
                         k, sel_idx_out, choice_valid_out, m_sel, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if (choice_idx_out !== 2'(m_choice)) begin
                    n_fail++;
                    $display("FAIL rand_idx_%0d: got %0d want %0d", k, choice_idx_out, m_choice);
                end
            end
        end
    endtask

    initial begin
        rst_in       = 1'b0;
        hcount_in    = '0;
        vcount_in    = '0;
        new_frame_in = 1'b0;
        nav_up_in    = 1'b0;
        nav_down_in  = 1'b0;
        select_in    = 1'b0;
        ack_in       = 1'b0;
        test_reset();
        test_nav();
        test_edge_events();
        test_confirm();
        test_done_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/menu_display.md
Name: menu_display

Overview:
- Parametrised successor to the single-button start screen.
- Renders N_BUTTONS equal rectangular buttons stacked vertically and tracks the selected button from up/down navigation pulses.
- On select, flashes the chosen button for a fixed number of frames, then reports the choice to the top-level game FSM through a valid/ack handshake.
- Sits between the pixel counters and the video mux; output is one 24-bit RGB pixel per clock, 0 meaning "no menu pixel".

Parameters:
- N_BUTTONS, 3, number of buttons (1..8).
- X0, 380, left edge of every button (pixels).
- Y0, 200, top edge of button 0 (pixels).
- BTN_W, 200, button width (pixels).
- BTN_H, 100, button height (pixels).
- GAP, 50, vertical gap between buttons; button i top = Y0 + i*(BTN_H+GAP).
- BTN_COLOR, 24'hF4_63_05, fill colour of unselected buttons.
- HL_COLOR, 24'hFF_FF_FF, fill colour of the selected button.
- BLINK_FRAMES, 8, frames per flash half-period in CONFIRM.
- FLASH_FRAMES, 32, total CONFIRM duration in frames.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  asynchronous reset, active-low.
- hcount_in  input  11  current pixel x.
- vcount_in  input  10  current pixel y.
- new_frame_in  input  1  one-cycle pulse at frame start.
- nav_up_in  input  1  one-cycle pulse: move selection up.
- nav_down_in  input  1  one-cycle pulse: move selection down.
- select_in  input  1  one-cycle pulse: confirm current selection.
- ack_in  input  1  consumer has taken the choice.
- display_out  output  24  registered RGB pixel; 0 outside all buttons.
- sel_idx_out  output  IW  current selection; IW = max(1,$clog2(N_BUTTONS)).
- choice_valid_out  output  1  high in DONE until ack.
- choice_idx_out  output  IW  confirmed index; valid while choice_valid_out is high.

Behaviour:
- Reset (rst_in low, async): state BROWSE, sel_idx_out=0, choice_valid_out=0, choice_idx_out=0, display_out=0, frame and blink counters=0.
- Hit test:
  - Pixel is inside button i iff X0 <= hcount < X0+BTN_W and Yi <= vcount < Yi+BTN_H, with half-open bounds.
  - All comparisons use widths wide enough to hold the extended bounds, so they cannot overflow.
- Pixel colour:
  - Inside selected button: HL_COLOR, or BTN_COLOR during CONFIRM off-phases.
  - Inside any other button: BTN_COLOR. Otherwise: 0.
  - display_out is registered, so latency is exactly 1 clock from hcount/vcount.
- FSM states:
  - BROWSE:
    - nav_down increments sel, nav_up decrements sel, both saturating at N_BUTTONS-1 and 0.
    - nav_up and nav_down together: no change.
    - select_in: latch choice_idx=sel, clear counters, go to CONFIRM. select wins over any nav pulse in the same cycle, and the pre-nav sel is latched.
  - CONFIRM:
    - nav and select are ignored.
    - Each new_frame_in increments the frame counter.
    - Blink phase = (frame_count / BLINK_FRAMES) odd → off (BTN_COLOR), even → on (HL_COLOR).
    - On the new_frame_in that brings the count to FLASH_FRAMES: go to DONE with choice_valid_out=1 on the next clock.
  - DONE:
    - choice_valid_out holds 1 and choice_idx_out is stable.
    - Selected button shows HL_COLOR. nav and select are ignored.
    - ack_in (level, sampled while valid): choice_valid_out=0 next clock, go to BROWSE, sel unchanged.
    - ack_in outside DONE: ignored.
- N_BUTTONS=1: nav never changes sel; select still runs CONFIRM → DONE.
- Reset mid-CONFIRM or mid-DONE: immediate return to the reset values above; no choice_valid_out pulse.

Optional Feature:
- Macro MENU_WRAP_NAV_EN.
- Defined: navigation wraps. nav_down at N_BUTTONS-1 goes to 0; nav_up at 0 goes to N_BUTTONS-1.
- Undefined: navigation saturates as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, defaults, sweep pixels:
  - (400,210) → 24'hFFFFFF one clock later.
  - (400,360) → 24'hF46305.
  - (579,299) → HL_COLOR; (580,299) → 0; (400,300) → 0.
  - (100,100) → 0.
- Three nav_down pulses from sel=0:
  - sel_idx_out = 1, then 2, then 2 (saturated).
  - With MENU_WRAP_NAV_EN: 1, 2, 0.
  - One nav_up from sel=0 with wrap → 2.
- sel=1, pulse select_in, drive 32 new_frame_in pulses:
  - Pixel (400,360) reads FFFFFF for frames 0–7, F46305 for frames 8–15, FFFFFF for 16–23, F46305 for 24–31.
  - choice_valid_out rises one clock after the 32nd pulse with choice_idx_out=1.
  - nav pulses sent during CONFIRM leave sel_idx_out=1.
- In DONE, hold ack_in low for 100 clocks: valid stays 1, idx stays 1. Raise ack_in: valid=0 next clock, state BROWSE, sel_idx_out=1.
- Edge events in BROWSE:
  - nav_up+nav_down in the same cycle at sel=1 → sel stays 1.
  - select_in+nav_down in the same cycle at sel=1 → CONFIRM with choice_idx=1.
- Assert rst_in low asynchronously after 10 CONFIRM frames → outputs reset without waiting for a clock edge (sel=0, valid=0, display_out=0). After release, no choice_valid_out pulse ever appears.
